// File: rtl/ncu_sii_pkg.sv
// Shared types and constants for the SII->NCU inbound receive path.
// Beat counts, packet widths, FSM state encoding and header field positions.
package ncu_sii_pkg;

    localparam int SII_NCU_BEATS = 4;
    localparam int HDR_W         = 16;
    localparam int PAYLOAD_W     = 128;
    localparam int PKT_W         = HDR_W + PAYLOAD_W + 1;

    localparam int HDR_TYPE_MSB  = 15;
    localparam int HDR_TYPE_LSB  = 13;
    localparam int HDR_TAG_MSB   = 12;
    localparam int HDR_TAG_LSB   = 9;
    localparam int HDR_INFO_MSB  = 8;
    localparam int HDR_INFO_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        P0   = 3'd2,
        P1   = 3'd3,
        P2   = 3'd4,
        P3   = 3'd5
    } sii_state_e;

    // Even parity per half-word; returns 1 when either half disagrees.
    function automatic logic beat_perr(input logic [31:0] d, input logic [1:0] p);
        return ((^d[31:16]) != p[1]) | ((^d[15:0]) != p[0]);
    endfunction

endpackage

// File: rtl/ncu_sii_pkt_fifo.sv
// Synchronous packet FIFO with a registered head; push and pop may coincide at any occupancy.
// Head is valid the cycle after a push into an empty FIFO; output holds its last value when empty.
module ncu_sii_pkt_fifo #(
    parameter int W     = 145,
    parameter int DEPTH = 4
) (
    input  logic                         iol2clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic                         dout_vld,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign dout_vld = (cnt != '0);

    always_ff @(posedge iol2clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
            // The incoming word becomes head only if nothing else will be ahead of it.
            if (push && ((cnt == '0) || ((cnt == CNT_W'(1)) && pop))) begin
                dout <= din;
            end else if (pop && (cnt > CNT_W'(1))) begin
                dout <= mem[ptr_inc(rd_ptr)];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge iol2clk) begin
        if (!rst) begin
            assert (!(push && !pop && (cnt == CNT_W'(DEPTH))));
            assert (!(pop && (cnt == '0)));
        end
    end
`endif

endmodule

// File: rtl/ncu_sii_ingress_deser.sv
// SII->NCU receiver: credit-limited gnt, 5-beat capture, parity check, packet FIFO.
// Latency gnt->pkt_vld 6 cycles; pkt_rdy backpressure stalls grants once credits run out.
module ncu_sii_ingress_deser
    import ncu_sii_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PERR_CNT_W = 8
) (
    input  logic                               iol2clk,
    input  logic                               rst,
    input  logic                               sii_ncu_req,
    input  logic [31:0]                        sii_ncu_data,
    input  logic [1:0]                         sii_ncu_dparity,
    output logic                               ncu_sii_gnt,
    output logic                               pkt_vld,
    input  logic                               pkt_rdy,
    output logic [HDR_W-1:0]                   pkt_hdr,
    output logic [PAYLOAD_W-1:0]               pkt_payload,
    output logic                               pkt_perr,
    output logic [PERR_CNT_W-1:0]              perr_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    sii_state_e       state, state_nxt;
    logic             gnt_q, gnt_nxt;
    logic [CNT_W-1:0] credits;
    logic             pop;
    logic             push;
    logic             credit_ok;
    logic             beat_err;
    logic [HDR_W-1:0] hdr_q;
    logic [95:0]      payload_q;
    logic             perr_q;
    logic             push_perr;
    logic [PKT_W-1:0] push_dat;
    logic [PKT_W-1:0] head_dat;

    assign pop       = pkt_vld & pkt_rdy;
    // A pop this cycle frees a slot the grant may immediately reuse.
    assign credit_ok = (credits != '0) | pop;
    assign beat_err  = beat_perr(sii_ncu_data, sii_ncu_dparity);
    assign push_perr = perr_q | beat_err;
    assign push_dat  = {push_perr, hdr_q, sii_ncu_data, payload_q};
    assign ncu_sii_gnt = gnt_q;

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt_q <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_q) begin
                    state_nxt = HDR;
                end else if (sii_ncu_req && credit_ok) begin
                    gnt_nxt = 1'b1;
                end
            end
            HDR: state_nxt = P0;
            P0:  state_nxt = P1;
            P1:  state_nxt = P2;
            P2: begin
                state_nxt = P3;
                // Deciding here puts the next gnt in P3 for back-to-back transfers.
                if (sii_ncu_req && credit_ok) begin
                    gnt_nxt = 1'b1;
                end
            end
            P3: begin
                push      = 1'b1;
                state_nxt = gnt_q ? HDR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            hdr_q     <= '0;
            payload_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            case (state)
                HDR: begin
                    hdr_q  <= sii_ncu_data[HDR_W-1:0];
                    perr_q <= beat_err;
                end
                P0: begin
                    payload_q[31:0] <= sii_ncu_data;
                    perr_q          <= perr_q | beat_err;
                end
                P1: begin
                    payload_q[63:32] <= sii_ncu_data;
                    perr_q           <= perr_q | beat_err;
                end
                P2: begin
                    payload_q[95:64] <= sii_ncu_data;
                    perr_q           <= perr_q | beat_err;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            credits  <= CNT_W'(FIFO_DEPTH);
            perr_cnt <= '0;
        end else begin
            credits <= credits + CNT_W'(pop) - CNT_W'(gnt_nxt);
            if (push && push_perr && (perr_cnt != '1)) begin
                perr_cnt <= perr_cnt + PERR_CNT_W'(1);
            end
        end
    end

    ncu_sii_pkt_fifo #(
        .W     (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iol2clk  (iol2clk),
        .rst      (rst),
        .push     (push),
        .din      (push_dat),
        .pop      (pop),
        .dout_vld (pkt_vld),
        .dout     (head_dat),
        .cnt      (fifo_cnt)
    );

    assign {pkt_perr, pkt_hdr, pkt_payload} = head_dat;

endmodule

// File: tb/tb_ncu_sii_ingress_deser.sv
// Scoreboard bench: SII model pushes expected packets, a monitor pops and compares on delivery.
module tb_ncu_sii_ingress_deser;

    localparam int DEPTH = 4;

    logic         iol2clk = 1'b0;
    logic         rst;
    logic         sii_ncu_req;
    logic [31:0]  sii_ncu_data;
    logic [1:0]   sii_ncu_dparity;
    logic         ncu_sii_gnt;
    logic         pkt_vld;
    logic         pkt_rdy;
    logic [15:0]  pkt_hdr;
    logic [127:0] pkt_payload;
    logic         pkt_perr;
    logic [7:0]   perr_cnt;
    logic [2:0]   fifo_cnt;

    ncu_sii_ingress_deser #(.FIFO_DEPTH(DEPTH), .PERR_CNT_W(8)) dut (
        .iol2clk         (iol2clk),
        .rst             (rst),
        .sii_ncu_req     (sii_ncu_req),
        .sii_ncu_data    (sii_ncu_data),
        .sii_ncu_dparity (sii_ncu_dparity),
        .ncu_sii_gnt     (ncu_sii_gnt),
        .pkt_vld         (pkt_vld),
        .pkt_rdy         (pkt_rdy),
        .pkt_hdr         (pkt_hdr),
        .pkt_payload     (pkt_payload),
        .pkt_perr        (pkt_perr),
        .perr_cnt        (perr_cnt),
        .fifo_cnt        (fifo_cnt)
    );

    always #5 iol2clk = ~iol2clk;

    typedef struct packed {
        logic [4:0][31:0] w;
        logic [4:0][1:0]  flip;
    } sii_pkt_t;

    typedef struct packed {
        logic [15:0]  hdr;
        logic [127:0] pl;
        logic         perr;
    } exp_t;

    sii_pkt_t pending[$];
    exp_t     exp_q[$];
    int       g_cyc[$];
    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       g_cnt = 0;
    int       beat = -1;
    int       max_cnt = 0;
    int       first_vld_cyc = -1;
    int       delivered = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic sii_pkt_t mk(input logic [31:0] h, input logic [31:0] b0, input logic [31:0] b1,
                                    input logic [31:0] b2, input logic [31:0] b3,
                                    input int fb, input logic [1:0] fv);
        sii_pkt_t p;
        p.w = {b3, b2, b1, b0, h};
        p.flip = '0;
        if (fb >= 0) p.flip[fb] = fv;
        return p;
    endfunction

    function automatic logic [1:0] par(input logic [31:0] d);
        return {^d[31:16], ^d[15:0]};
    endfunction

    always @(posedge iol2clk) cyc <= cyc + 1;

    // SII model: drives one beat per cycle after each grant.
    initial begin : sii_model
        sii_pkt_t cur;
        exp_t     e;
        sii_ncu_req = 1'b0;
        sii_ncu_data = '0;
        sii_ncu_dparity = '0;
        cur = '0;
        forever begin
            @(posedge iol2clk);
            #1;
            if (rst) begin
                beat = -1;
                sii_ncu_data = '0;
                sii_ncu_dparity = '0;
                exp_q.delete();
            end else begin
                if (beat >= 0) begin
                    sii_ncu_data    = cur.w[beat];
                    sii_ncu_dparity = par(cur.w[beat]) ^ cur.flip[beat];
                    if (beat == 4) begin
                        e.hdr  = cur.w[0][15:0];
                        e.pl   = {cur.w[4], cur.w[3], cur.w[2], cur.w[1]};
                        e.perr = |cur.flip;
                        exp_q.push_back(e);
                        beat = -1;
                    end else begin
                        beat++;
                    end
                end
                if (ncu_sii_gnt) begin
                    g_cnt++;
                    g_cyc.push_back(cyc);
                    if (pending.size() == 0) begin
                        chk("spurious_gnt", 1, 0);
                    end else begin
                        cur = pending.pop_front();
                        beat = 0;
                    end
                end
            end
            sii_ncu_req = (pending.size() != 0);
        end
    end

    // Monitor: compares every accepted head against the scoreboard.
    always @(negedge iol2clk) begin
        exp_t e;
        if (!rst) begin
            if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
            if (pkt_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (pkt_vld && pkt_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pkt", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pkt_hdr", pkt_hdr, e.hdr);
                    chk("pkt_payload", pkt_payload, e.pl);
                    chk("pkt_perr", pkt_perr, e.perr);
                    delivered++;
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge iol2clk);
            if (pending.size() == 0 && beat < 0 && exp_q.size() == 0 && !pkt_vld) break;
        end
        if (n >= budget) chk("idle_timeout", 1, 0);
    endtask

    initial begin : main
        int n0;
        int d0;
        int k;
        rst = 1'b1;
        pkt_rdy = 1'b0;
        repeat (3) @(posedge iol2clk);
        @(negedge iol2clk);
        chk("rst_gnt", ncu_sii_gnt, 0);
        chk("rst_vld", pkt_vld, 0);
        chk("rst_hdr", pkt_hdr, 0);
        chk("rst_payload", pkt_payload, 0);
        chk("rst_perr", pkt_perr, 0);
        chk("rst_perr_cnt", perr_cnt, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        @(posedge iol2clk); #2;
        rst = 1'b0;

        // Single packet with hand-checked head contents and latency.
        pkt_rdy = 1'b1;
        first_vld_cyc = -1;
        pending.push_back(mk(32'h0000A5C3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, -1, 2'b00));
        wait_idle(100);
        chk("t1_latency", first_vld_cyc - g_cyc[g_cyc.size()-1], 6);
        chk("t1_hdr", pkt_hdr, 16'hA5C3);
        chk("t1_payload", pkt_payload, 128'h44444444_33333333_22222222_11111111);
        chk("t1_perr", pkt_perr, 0);

        // Back-to-back packets.
        max_cnt = 0;
        n0 = g_cyc.size();
        d0 = delivered;
        for (int i = 0; i < 3; i++)
            pending.push_back(mk(32'h0000_1000 + i, 32'h1000_0000 + i, 32'h2000_0000 + i,
                                 32'h3000_0000 + i, 32'h4000_0000 + i, -1, 2'b00));
        wait_idle(200);
        chk("t2_gap01", g_cyc[n0+1] - g_cyc[n0], 5);
        chk("t2_gap12", g_cyc[n0+2] - g_cyc[n0+1], 5);
        chk("t2_max_cnt", max_cnt, 1);
        chk("t2_delivered", delivered - d0, 3);

        // Backpressure: credits cap grants at the FIFO depth.
        pkt_rdy = 1'b0;
        n0 = g_cnt;
        d0 = delivered;
        for (int i = 0; i < 6; i++)
            pending.push_back(mk(32'hFFFF_2000 + i, 32'hA000_0000 + i, 32'hB000_0000 + i,
                                 32'hC000_0000 + i, 32'hD000_0000 + i, -1, 2'b00));
        repeat (60) @(negedge iol2clk);
        chk("t3_gnts", g_cnt - n0, 4);
        chk("t3_fifo_full", fifo_cnt, 4);
        @(posedge iol2clk); #2;
        pkt_rdy = 1'b1;
        @(posedge iol2clk); #2;
        pkt_rdy = 1'b0;
        repeat (30) @(negedge iol2clk);
        chk("t3_one_more_gnt", g_cnt - n0, 5);
        chk("t3_fifo_refull", fifo_cnt, 4);

        // Drain from full while more packets keep arriving.
        for (int i = 0; i < 3; i++)
            pending.push_back(mk(32'h0000_3000 + i, 32'h5000_0000 + i, 32'h6000_0000 + i,
                                 32'h7000_0000 + i, 32'h8000_0000 + i, -1, 2'b00));
        max_cnt = 0;
        @(posedge iol2clk); #2;
        pkt_rdy = 1'b1;
        wait_idle(300);
        chk("t6_max_cnt", max_cnt, 4);
        chk("t6_delivered", delivered - d0, 9);

        // Parity: only the middle packet has a bad upper half on payload beat 2.
        pending.push_back(mk(32'h0000_4001, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404, -1, 2'b00));
        pending.push_back(mk(32'h0000_4002, 32'h0505_0505, 32'h0606_0606, 32'h0707_0707, 32'h0808_0808, 3, 2'b10));
        pending.push_back(mk(32'h0000_4003, 32'h0909_0909, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, -1, 2'b00));
        wait_idle(200);
        chk("t4_perr_cnt_1", perr_cnt, 1);
        for (int i = 0; i < 300; i++)
            pending.push_back(mk(32'h0000_5000 + i, i, i + 1, i + 2, i + 3, 0, 2'b01));
        wait_idle(3000);
        chk("t4_perr_cnt_sat", perr_cnt, 8'hFF);

        // Reset while the packet is in P1.
        n0 = g_cnt;
        pending.push_back(mk(32'h0000_6001, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004, -1, 2'b00));
        for (k = 0; k < 50 && g_cnt == n0; k++) @(negedge iol2clk);
        chk("t5_gnt_seen", g_cnt - n0, 1);
        repeat (3) @(posedge iol2clk);
        #2 rst = 1'b1;
        @(posedge iol2clk); #2;
        rst = 1'b0;
        @(negedge iol2clk);
        chk("t5_gnt", ncu_sii_gnt, 0);
        chk("t5_vld", pkt_vld, 0);
        chk("t5_fifo_cnt", fifo_cnt, 0);
        chk("t5_perr_cnt", perr_cnt, 0);
        d0 = delivered;
        pending.push_back(mk(32'h0000_6002, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004, -1, 2'b00));
        wait_idle(100);
        chk("t5_delivered", delivered - d0, 1);
        chk("t5_hdr", pkt_hdr, 16'h6002);
        chk("t5_payload", pkt_payload, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
